// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit beside the EX-stage ALU: radix-2 shift-add MULT/MULTU, restoring DIV/DIVU.
// Optional MADD/MSUB accumulate into sampled HI:LO when built with MULDIV_MADD_EN defined.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [1:0]       i_acc,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_whilo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

`ifdef MULDIV_MADD_EN
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DONE, S_ACC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`endif

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t state, state_nxt;

  // opnd holds the multiplicand (MUL) or the divisor (DIV); work holds the
  // partial product, or {remainder, dividend/quotient shift register}.
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] work;
  logic [CW-1:0]      cnt;
  logic               neg_a;
  logic               neg_x;

  logic               start_ok;
  logic signed [WIDTH-1:0] rs_s, rt_s;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic               last;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0]   div_hi, div_lo;

`ifdef MULDIV_MADD_EN
  logic               acc_en;
  logic               acc_sub;
  logic [2*WIDTH-1:0] hilo_s;
  logic [2*WIDTH-1:0] acc_res;
`else
  logic               unused_acc;
  assign unused_acc = ^{i_acc, i_hi, i_lo};
`endif

  assign start_ok = i_start & ~i_cancel;
  assign rs_s     = i_rs;
  assign rt_s     = i_rt;
  assign rs_neg   = i_op[0] & (rs_s < 0);
  assign rt_neg   = i_op[0] & (rt_s < 0);
  assign rs_mag   = cond_neg(i_rs, rs_neg);
  assign rt_mag   = cond_neg(i_rt, rt_neg);
  assign last     = (cnt == CW'(WIDTH - 1));

  // One shift-add step: add multiplicand into the high half when the current multiplier bit is set.
  assign mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {mul_sum, work[WIDTH-1:1]};
  assign mul_res = cond_neg2(mul_nxt, neg_x);

  // One restoring step: the shifted partial remainder is WIDTH+1 bits so the compare cannot overflow.
  assign div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd;
  assign div_nxt   = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), work[WIDTH-2:0], div_ge};
  assign div_hi    = cond_neg(div_nxt[2*WIDTH-1:WIDTH], neg_a);
  assign div_lo    = cond_neg(div_nxt[WIDTH-1:0], neg_x);

`ifdef MULDIV_MADD_EN
  assign acc_res = acc_sub ? (hilo_s - work) : (hilo_s + work);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (!i_op[1])        state_nxt = S_MUL;
          else if (i_rt == '0) state_nxt = S_DONE;
          else                 state_nxt = S_DIV;
        end
      end
      S_MUL: begin
        if (last) begin
`ifdef MULDIV_MADD_EN
          state_nxt = acc_en ? S_ACC : S_DONE;
`else
          state_nxt = S_DONE;
`endif
        end
      end
      S_DIV: if (last) state_nxt = S_DONE;
`ifdef MULDIV_MADD_EN
      S_ACC: state_nxt = S_DONE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (i_cancel) state_nxt = S_IDLE;
  end

  always_comb begin
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state)
      S_MUL, S_DIV: o_busy = 1'b1;
`ifdef MULDIV_MADD_EN
      S_ACC:        o_busy = 1'b1;
`endif
      S_DONE:       o_done = 1'b1;
      default: ;
    endcase
    o_whilo = o_done;
  end

  // Datapath state carries no reset; it is always reloaded on an accepted start.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          cnt   <= '0;
          neg_a <= rs_neg;
          neg_x <= rs_neg ^ rt_neg;
          opnd  <= i_op[1] ? rt_mag : rs_mag;
          work  <= {{WIDTH{1'b0}}, (i_op[1] ? rs_mag : rt_mag)};
`ifdef MULDIV_MADD_EN
          acc_en  <= ~i_op[1] & (i_acc == 2'b01 || i_acc == 2'b10);
          acc_sub <= (i_acc == 2'b10);
          hilo_s  <= {i_hi, i_lo};
`endif
        end
      end
      S_MUL: begin
        work <= last ? mul_res : mul_nxt;
        cnt  <= cnt + CW'(1);
      end
      S_DIV: begin
        work <= div_nxt;
        cnt  <= cnt + CW'(1);
      end
      default: ;
    endcase
  end

  // Result registers load only on the edge entering DONE, so a cancel leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_hi <= '0;
      o_lo <= '0;
    end else if (state_nxt == S_DONE) begin
      case (state)
        S_IDLE:  {o_hi, o_lo} <= {i_rs, {WIDTH{1'b1}}};
        S_MUL:   {o_hi, o_lo} <= mul_res;
        S_DIV:   {o_hi, o_lo} <= {div_hi, div_lo};
`ifdef MULDIV_MADD_EN
        S_ACC:   {o_hi, o_lo} <= acc_res;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv (WIDTH=32); expectations follow MULDIV_MADD_EN when it is defined.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [1:0]  i_acc = 2'b00;
  logic [31:0] i_rs = '0, i_rt = '0, i_hi = '0, i_lo = '0;
  logic        i_cancel = 1'b0;
  logic        o_busy, o_done, o_whilo;
  logic [31:0] o_hi, o_lo;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_acc(i_acc),
    .i_rs(i_rs), .i_rt(i_rt), .i_hi(i_hi), .i_lo(i_lo), .i_cancel(i_cancel),
    .o_busy(o_busy), .o_done(o_done), .o_whilo(o_whilo), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] last_res = '0;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [1:0] acc,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint      sa, sr, q, r;
    logic [63:0] p;
    sa = longint'($signed(rs));
    sr = longint'($signed(rt));
    case (op)
      2'b00: p = {32'd0, rs} * {32'd0, rt};
      2'b01: p = sa * sr;
      2'b10: p = (rt == 0) ? {rs, 32'hFFFF_FFFF} : {rs % rt, rs / rt};
      default: begin
        if (rt == 0) p = {rs, 32'hFFFF_FFFF};
        else begin
          q = sa / sr;
          r = sa % sr;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
`ifdef MULDIV_MADD_EN
    if (!op[1] && acc == 2'b01) p = {hi, lo} + p;
    else if (!op[1] && acc == 2'b10) p = {hi, lo} - p;
`else
    if (acc == 2'b11 && hi == lo) p = p;
`endif
    return p;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [1:0] acc, input logic [31:0] rt);
    if (op[1] && rt == 0) return 1;
`ifdef MULDIV_MADD_EN
    if (!op[1] && (acc == 2'b01 || acc == 2'b10)) return 34;
`else
    if (acc == 2'b11 && op == 2'b11) return 33;
`endif
    return 33;
  endfunction

  // Drive a one-cycle start (accepted at edge T), queue the expectation; returns in cycle T+1.
  task automatic drive_start(input logic [1:0] op, input logic [1:0] acc, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [31:0] hi, input logic [31:0] lo);
    exp_t        e;
    logic [63:0] r;
    r     = model(op, acc, rs, rt, hi, lo);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.lat = exp_lat(op, acc, rt);
    sb.push_back(e);
    i_op = op; i_acc = acc; i_rs = rs; i_rt = rt; i_hi = hi; i_lo = lo;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Bounded wait: lat is the cycle index k (T+k) of o_done, or -1 on timeout.
  task automatic wait_done(output int lat, output int busy);
    lat  = -1;
    busy = 0;
    for (int k = 1; k <= 100; k++) begin
      if (o_busy) busy++;
      if (o_done) begin
        lat = k;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_start = 1'b1; i_cancel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_busy, o_done, o_whilo, o_hi, o_lo} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b done=%b whilo=%b hi=%h lo=%h required all zero",
               o_busy, o_done, o_whilo, o_hi, o_lo);
    end
    rst = 1'b0; i_start = 1'b0; i_cancel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [1:0]  ops[6] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    logic [31:0] rss[6] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] rts[6] = '{32'd5, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
    int lat, busy;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) drive_start(ops[i], 2'b00, rss[i], rts[i], 32'h0, 32'h0);
      else       drive_start({1'b0, 1'($urandom_range(1))}, 2'b00, $urandom, $urandom, 32'h0, 32'h0);
      wait_done(lat, busy);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_fail++; $display("FAIL mul[%0d] latency: got %0d required %0d", i, lat, e.lat);
      end
      n_cmp++;
      if ({o_whilo, o_hi, o_lo} !== {1'b1, e.hi, e.lo}) begin
        n_fail++; $display("FAIL mul[%0d] result: got whilo=%b %h_%h required 1 %h_%h", i, o_whilo, o_hi, o_lo, e.hi, e.lo);
      end
      n_cmp++;
      if (busy !== e.lat - 1) begin
        n_fail++; $display("FAIL mul[%0d] busy cycles: got %0d required %0d", i, busy, e.lat - 1);
      end
      last_res = {e.hi, e.lo};
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div;
    logic [1:0]  ops[7] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
    logic [31:0] rss[7] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd3};
    logic [31:0] rts[7] = '{32'hFFFF_FFFE, 32'h10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd9, 32'h8000_0000};
    int lat, busy;
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      if (i < 7) drive_start(ops[i], 2'b00, rss[i], rts[i], 32'h0, 32'h0);
      else       drive_start({1'b1, 1'($urandom_range(1))}, 2'b00, $urandom, $urandom_range(32'hFFFF, 1), 32'h0, 32'h0);
      wait_done(lat, busy);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_fail++; $display("FAIL div[%0d] latency: got %0d required %0d", i, lat, e.lat);
      end
      n_cmp++;
      if ({o_whilo, o_hi, o_lo} !== {1'b1, e.hi, e.lo}) begin
        n_fail++; $display("FAIL div[%0d] result: got whilo=%b %h_%h required 1 %h_%h", i, o_whilo, o_hi, o_lo, e.hi, e.lo);
      end
      n_cmp++;
      if (busy !== e.lat - 1) begin
        n_fail++; $display("FAIL div[%0d] busy cycles: got %0d required %0d", i, busy, e.lat - 1);
      end
      last_res = {e.hi, e.lo};
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div0;
    logic [1:0]  ops[2] = '{2'b10, 2'b11};
    logic [31:0] rss[2] = '{32'h0000_1234, 32'hFFFF_FF00};
    int lat, busy;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive_start(ops[i], 2'b00, rss[i], 32'h0, 32'h0, 32'h0);
      wait_done(lat, busy);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_fail++; $display("FAIL div0[%0d] latency: got %0d required %0d", i, lat, e.lat);
      end
      n_cmp++;
      if ({o_whilo, o_hi, o_lo} !== {1'b1, e.hi, e.lo}) begin
        n_fail++; $display("FAIL div0[%0d] result: got whilo=%b %h_%h required 1 %h_%h", i, o_whilo, o_hi, o_lo, e.hi, e.lo);
      end
      n_cmp++;
      if (busy !== 0) begin
        n_fail++; $display("FAIL div0[%0d] busy cycles: got %0d required 0", i, busy);
      end
      last_res = {e.hi, e.lo};
      @(posedge clk); #1;
    end
  endtask

  task automatic test_acc;
    logic [1:0]  ops[3] = '{2'b00, 2'b01, 2'b01};
    logic [1:0]  accs[3] = '{2'b01, 2'b10, 2'b01};
    logic [31:0] rss[3] = '{32'd1, 32'd3, 32'hFFFF_FFFE};
    logic [31:0] rts[3] = '{32'd1, 32'd4, 32'd5};
    logic [31:0] his[3] = '{32'h0, 32'h0, 32'h0000_0001};
    logic [31:0] los[3] = '{32'hFFFF_FFFF, 32'd10, 32'h0000_0004};
    int lat, busy;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive_start(ops[i], accs[i], rss[i], rts[i], his[i], los[i]);
      wait_done(lat, busy);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_fail++; $display("FAIL acc[%0d] latency: got %0d required %0d", i, lat, e.lat);
      end
      n_cmp++;
      if ({o_whilo, o_hi, o_lo} !== {1'b1, e.hi, e.lo}) begin
        n_fail++; $display("FAIL acc[%0d] result: got whilo=%b %h_%h required 1 %h_%h", i, o_whilo, o_hi, o_lo, e.hi, e.lo);
      end
      n_cmp++;
      if (busy !== e.lat - 1) begin
        n_fail++; $display("FAIL acc[%0d] busy cycles: got %0d required %0d", i, busy, e.lat - 1);
      end
      last_res = {e.hi, e.lo};
      @(posedge clk); #1;
    end
    i_acc = 2'b00;
  endtask

  task automatic test_cancel;
    int   ndone, first;
    logic seen;
    exp_t e;
    // Cancel sampled at edge T+10: idle in cycle T+11, no write, outputs keep the last result.
    i_op = 2'b00; i_acc = 2'b00; i_rs = 32'hDEAD_BEEF; i_rt = 32'h0000_0777;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    i_cancel = 1'b1;
    @(posedge clk); #1;
    i_cancel = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL cancel idle: got busy=%b required 0", o_busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen |= o_whilo;
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({seen, o_hi, o_lo} !== {1'b0, last_res}) begin
      n_fail++; $display("FAIL cancel hold: got whilo_seen=%b %h_%h required 0 %h", seen, o_hi, o_lo, last_res);
    end

    // A start pulsed while busy is ignored: exactly one completion, for the first operands.
    drive_start(2'b00, 2'b00, 32'h0000_ABCD, 32'h0001_0003, 32'h0, 32'h0);
    e = sb.pop_front();
    ndone = 0; first = -1;
    for (int k = 1; k <= 80; k++) begin
      i_start = (k >= 3 && k <= 5);
      i_rs = 32'h1111_1111;
      if (o_done) begin
        ndone++;
        if (first < 0) begin
          first = k;
          n_cmp++;
          if ({o_hi, o_lo} !== {e.hi, e.lo}) begin
            n_fail++; $display("FAIL busy_start result: got %h_%h required %h_%h", o_hi, o_lo, e.hi, e.lo);
          end
        end
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    n_cmp++;
    if (ndone !== 1 || first !== e.lat) begin
      n_fail++; $display("FAIL busy_start pulses: got count=%0d at %0d required 1 at %0d", ndone, first, e.lat);
    end
    last_res = {e.hi, e.lo};

    // Cancel beats a simultaneous start in IDLE.
    i_op = 2'b00; i_rs = 32'd3; i_rt = 32'd3;
    i_start = 1'b1; i_cancel = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_cancel = 1'b0;
    seen = o_busy;
    for (int k = 0; k < 40; k++) begin
      seen |= o_whilo | o_busy;
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({seen, o_hi, o_lo} !== {1'b0, last_res}) begin
      n_fail++; $display("FAIL cancel_start: got activity=%b %h_%h required 0 %h", seen, o_hi, o_lo, last_res);
    end

    // Reset mid-operation clears every output on the next edge.
    i_op = 2'b01; i_rs = 32'h0000_0100; i_rt = 32'h0000_0200;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({o_busy, o_done, o_whilo, o_hi, o_lo} !== 67'd0) begin
      n_fail++; $display("FAIL mid_reset: got busy=%b done=%b whilo=%b hi=%h lo=%h required all zero",
                         o_busy, o_done, o_whilo, o_hi, o_lo);
    end
    last_res = '0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_back_to_back;
    int lat, busy;
    exp_t e;
    drive_start(2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    wait_done(lat, busy);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || {o_hi, o_lo} !== {e.hi, e.lo}) begin
      n_fail++; $display("FAIL b2b first: got lat=%0d %h_%h required lat=%0d %h_%h", lat, o_hi, o_lo, e.lat, e.hi, e.lo);
    end
    // Start raised already in the DONE cycle must not be taken until IDLE.
    i_op = 2'b01; i_acc = 2'b00; i_rs = 32'hFFFF_FFFA; i_rt = 32'd9;
    i_start = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({o_busy, o_done} !== 2'b00) begin
      n_fail++; $display("FAIL b2b idle gap: got busy=%b done=%b required 00", o_busy, o_done);
    end
    drive_start(2'b01, 2'b00, 32'hFFFF_FFFA, 32'd9, 32'h0, 32'h0);
    wait_done(lat, busy);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || busy !== e.lat - 1 || {o_whilo, o_hi, o_lo} !== {1'b1, e.hi, e.lo}) begin
      n_fail++; $display("FAIL b2b second: got lat=%0d busy=%0d %h_%h required lat=%0d busy=%0d %h_%h",
                         lat, busy, o_hi, o_lo, e.lat, e.lat - 1, e.hi, e.lo);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div0;
    test_acc;
    test_cancel;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
